adder_arbiter: RTL

- Shares one 8-bit ripple-CLA adder/subtractor between two requesters: requester 0 is the ALU instruction path, requester 1 is the PC/address incrementer.
- Arbitrates round-robin, latches the winner's operands and drives the adder's en/ready handshake.
- Captures the adder's sum and carry, and returns them with a one-cycle done pulse to the requester that was granted.
- Sits between the control unit and the adder; no requester drives the adder directly.

---
 rtl/adder_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one adder/subtractor between two requesters
module adder_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             sub0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             sub1,
  output logic [1:0]       gnt,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             err,
  output logic             busy,
  output logic             adder_en,
  output logic             adder_c_in,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  input  logic [WIDTH-1:0] adder_out,
  input  logic             adder_c_out,
  input  logic             adder_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_n;
  logic [1:0]       gnt_n;
  logic [WIDTH-1:0] result_n, a_q, a_n, b_q, b_n;
  logic             c_out_n, err_n, cin_q, cin_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             last, last_n;
  logic             win1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      result <= '0;
      c_out  <= 1'b0;
      err    <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      cin_q  <= 1'b0;
      cnt    <= '0;
      last   <= 1'b1;
    end else begin
      state  <= state_n;
      gnt    <= gnt_n;
      result <= result_n;
      c_out  <= c_out_n;
      err    <= err_n;
      a_q    <= a_n;
      b_q    <= b_n;
      cin_q  <= cin_n;
      cnt    <= cnt_n;
      last   <= last_n;
    end
  end

  // On a tie the requester not served last wins; a lone requester always wins.
  always_comb begin
    win1 = (req0 && req1) ? ~last : req1;
  end

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    result_n = result;
    c_out_n  = c_out;
    err_n    = err;
    a_n      = a_q;
    b_n      = b_q;
    cin_n    = cin_q;
    cnt_n    = cnt;
    last_n   = last;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          a_n     = win1 ? a1 : a0;
          b_n     = win1 ? b1 : b0;
          cin_n   = win1 ? sub1 : sub0;
          gnt_n   = win1 ? 2'b10 : 2'b01;
          cnt_n   = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        cnt_n = cnt + CNT_W'(1);
        if (adder_ready) begin
          result_n = adder_out;
          c_out_n  = adder_c_out;
          err_n    = 1'b0;
          state_n  = DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          c_out_n = 1'b0;
          err_n   = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        last_n  = gnt[1];
        gnt_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // The low adder_en in DONE is what clears the adder's ready before the next operation.
  assign adder_en   = (state == BUSY);
  assign busy       = (state != IDLE);
  assign done0      = (state == DONE) && gnt[0];
  assign done1      = (state == DONE) && gnt[1];
  assign adder_a    = a_q;
  assign adder_b    = b_q;
  assign adder_c_in = cin_q;

endmodule
